// File: rtl/tama_needs_fsm.sv
// Need-level tracker and one-hot pet-state FSM feeding the display/sprite logic.
// Define TAMA_DEATH_EN to make the sticky DEATH state reachable.
module tama_needs_fsm #(
  parameter int unsigned TICK_DIV      = 5,
  parameter int unsigned N_NEEDS       = 2,
  parameter int unsigned LVL_W         = 3,
  parameter int unsigned LVL_MAX       = 4,
  parameter int unsigned LOW_TH        = 1,
  parameter int unsigned DECAY_TICKS   = 4,
  parameter int unsigned RECOVER_TICKS = 2,
  parameter int unsigned FEED_STEP     = 2,
  parameter int unsigned DEATH_TICKS   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       botonSleep,
  input  logic                       botonAwake,
  input  logic [N_NEEDS-1:0]         botonFeed,
  output logic [N_NEEDS*LVL_W-1:0]   level_bus,
  output logic [N_NEEDS-1:0]         low_mask,
  output logic                       game_tick,
  output logic                       sign_IDLE,
  output logic                       sign_NEUTRAL,
  output logic                       sign_LOW,
  output logic                       sign_SLEEP,
  output logic                       sign_DEATH
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned DEC_W  = $clog2(DECAY_TICKS + 1);
  localparam int unsigned REC_W  = $clog2(RECOVER_TICKS + 1);
  localparam int unsigned SUM_W  = LVL_W + $clog2(FEED_STEP + 1) + 1;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_NEUTRAL = 5'b00010,
    S_LOW     = 5'b00100,
    S_SLEEP   = 5'b01000,
    S_DEATH   = 5'b10000
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic                sleep_q, awake_q;
  logic [N_NEEDS-1:0]  feed_q;
  logic [LVL_W-1:0]    lvl_q [N_NEEDS];
  logic [LVL_W-1:0]    lvl_d [N_NEEDS];
  logic [DEC_W-1:0]    dec_q [N_NEEDS];
  logic [DEC_W-1:0]    dec_d [N_NEEDS];
  logic [REC_W-1:0]    rec_q, rec_d;
  logic [N_NEEDS-1:0]  low_q, low_d;

  logic                sleep_edge_c, awake_edge_c;
  logic [N_NEEDS-1:0]  feed_edge_c;
  logic                death_hit_c;
  logic                dec_hit;
  logic [SUM_W-1:0]    sum;

  assign sleep_edge_c = botonSleep & ~sleep_q;
  assign awake_edge_c = botonAwake & ~awake_q;
  assign feed_edge_c  = botonFeed & ~feed_q;

  // Tick divider, per-channel decay/feed, energy recovery while asleep.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    tick_d     = 1'b0;
    if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end
    dec_hit = 1'b0;
    sum     = '0;
    for (int i = 0; i < N_NEEDS; i++) begin
      lvl_d[i] = lvl_q[i];
      dec_d[i] = dec_q[i];
      dec_hit  = 1'b0;
      if (state_q != S_DEATH) begin
        if (i == 0 && state_q == S_SLEEP) begin
          dec_d[i] = '0;
        end else if (tick_q) begin
          if (dec_q[i] == DEC_W'(DECAY_TICKS - 1)) begin
            dec_d[i] = '0;
            dec_hit  = 1'b1;
          end else begin
            dec_d[i] = dec_q[i] + DEC_W'(1);
          end
        end
        sum = SUM_W'(lvl_q[i]);
        if (i != 0 && feed_edge_c[i] && (state_q == S_NEUTRAL || state_q == S_LOW))
          sum = sum + SUM_W'(FEED_STEP);
        if (dec_hit && sum != '0)
          sum = sum - SUM_W'(1);
        if (sum > SUM_W'(LVL_MAX))
          sum = SUM_W'(LVL_MAX);
        lvl_d[i] = LVL_W'(sum);
      end
    end
    rec_d = '0;
    if (state_q == S_SLEEP) begin
      rec_d = rec_q;
      if (tick_q) begin
        if (rec_q == REC_W'(RECOVER_TICKS - 1)) begin
          rec_d = '0;
          if (lvl_q[0] < LVL_W'(LVL_MAX))
            lvl_d[0] = lvl_q[0] + LVL_W'(1);
        end else begin
          rec_d = rec_q + REC_W'(1);
        end
      end
    end
    for (int i = 0; i < N_NEEDS; i++)
      low_d[i] = (lvl_d[i] <= LVL_W'(LOW_TH));
  end

  // Pet-state next-state logic, driven by registered levels.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (tick_q) state_d = S_NEUTRAL;
      S_NEUTRAL, S_LOW: begin
        state_d = (|low_q) ? S_LOW : S_NEUTRAL;
        if (sleep_edge_c && !awake_edge_c) state_d = S_SLEEP;
      end
      S_SLEEP: begin
        if (awake_edge_c || lvl_q[0] == LVL_W'(LVL_MAX))
          state_d = (|low_q) ? S_LOW : S_NEUTRAL;
      end
      S_DEATH: state_d = S_DEATH;
      default: state_d = S_IDLE;
    endcase
    if (death_hit_c) state_d = S_DEATH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      sleep_q    <= 1'b0;
      awake_q    <= 1'b0;
      feed_q     <= '0;
      rec_q      <= '0;
      low_q      <= '0;
      for (int i = 0; i < N_NEEDS; i++) begin
        lvl_q[i] <= LVL_W'(LVL_MAX);
        dec_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      sleep_q    <= botonSleep;
      awake_q    <= botonAwake;
      feed_q     <= botonFeed;
      rec_q      <= rec_d;
      low_q      <= low_d;
      for (int i = 0; i < N_NEEDS; i++) begin
        lvl_q[i] <= lvl_d[i];
        dec_q[i] <= dec_d[i];
      end
    end
  end

`ifdef TAMA_DEATH_EN
  localparam int unsigned DTH_W = $clog2(DEATH_TICKS + 1);
  logic [DTH_W-1:0] death_q, death_d;
  logic             any_zero_c;

  // Counts ticks spent with some channel empty; frozen once dead.
  always_comb begin
    any_zero_c = 1'b0;
    for (int i = 0; i < N_NEEDS; i++)
      if (lvl_q[i] == '0) any_zero_c = 1'b1;
    death_d = death_q;
    if (state_q != S_DEATH) begin
      if (!any_zero_c)
        death_d = '0;
      else if (tick_q && death_q != DTH_W'(DEATH_TICKS))
        death_d = death_q + DTH_W'(1);
    end
    death_hit_c = (state_q != S_IDLE) && (state_q != S_DEATH) &&
                  (death_d == DTH_W'(DEATH_TICKS));
  end

  always_ff @(posedge clk) begin
    if (rst) death_q <= '0;
    else     death_q <= death_d;
  end

  assign sign_DEATH = (state_q == S_DEATH);
`else
  assign death_hit_c = 1'b0;
  assign sign_DEATH  = 1'b0;
`endif

  for (genvar g = 0; g < N_NEEDS; g++) begin : g_bus
    assign level_bus[g*LVL_W +: LVL_W] = lvl_q[g];
  end

  assign low_mask     = low_q;
  assign game_tick    = tick_q;
  assign sign_IDLE    = (state_q == S_IDLE);
  assign sign_NEUTRAL = (state_q == S_NEUTRAL);
  assign sign_LOW     = (state_q == S_LOW);
  assign sign_SLEEP   = (state_q == S_SLEEP);

endmodule

// File: tb/tb_tama_needs_fsm.sv
// Directed bench for tama_needs_fsm at default parameters; expectations follow TAMA_DEATH_EN.
module tb_tama_needs_fsm;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_NEU  = 5'b00010;
  localparam logic [4:0] ST_LOW  = 5'b00100;
  localparam logic [4:0] ST_SLP  = 5'b01000;
  localparam logic [4:0] ST_DTH  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       botonSleep = 1'b0;
  logic       botonAwake = 1'b0;
  logic [1:0] botonFeed = 2'b00;
  logic [5:0] level_bus;
  logic [1:0] low_mask;
  logic       game_tick;
  logic       sign_IDLE, sign_NEUTRAL, sign_LOW, sign_SLEEP, sign_DEATH;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;

  tama_needs_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .botonSleep   (botonSleep),
    .botonAwake   (botonAwake),
    .botonFeed    (botonFeed),
    .level_bus    (level_bus),
    .low_mask     (low_mask),
    .game_tick    (game_tick),
    .sign_IDLE    (sign_IDLE),
    .sign_NEUTRAL (sign_NEUTRAL),
    .sign_LOW     (sign_LOW),
    .sign_SLEEP   (sign_SLEEP),
    .sign_DEATH   (sign_DEATH)
  );

  always #5 clk = ~clk;

  // Edges since reset was last sampled high; read at the falling edge.
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  function automatic logic [5:0] lv(input int ch1, input int ch0);
    lv = {3'(ch1), 3'(ch0)};
  endfunction

  function automatic logic [4:0] st_now();
    st_now = {sign_DEATH, sign_SLEEP, sign_LOW, sign_NEUTRAL, sign_IDLE};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, ecnt, obs, exp);
    end
  endtask

  task automatic goto_edge(input int e);
    int guard;
    guard = 0;
    while (ecnt < e) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        n_err++;
        $display("FAIL goto_edge timeout waiting for edge %0d (at %0d)", e, ecnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "edge wait expired");
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    botonSleep = 1'b0;
    botonAwake = 1'b0;
    botonFeed  = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(st_now()), 32'(ST_IDLE));
    chk("rst_levels", 32'(level_bus), 32'(lv(4, 4)));
    chk("rst_low", 32'(low_mask), 32'd0);
    chk("rst_tick", 32'(game_tick), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Reset, first tick, IDLE -> NEUTRAL
    do_reset();
    goto_edge(4);   chk("tick_early", 32'(game_tick), 32'd0);
    goto_edge(5);   chk("tick_first", 32'(game_tick), 32'd1);
                    chk("idle_at_tick", 32'(st_now()), 32'(ST_IDLE));
    goto_edge(6);   chk("neutral", 32'(st_now()), 32'(ST_NEU));
                    chk("tick_single", 32'(game_tick), 32'd0);

    // Free-running decay to LOW
    goto_edge(20);  chk("lvl_pre_decay", 32'(level_bus), 32'(lv(4, 4)));
    goto_edge(21);  chk("lvl_decay1", 32'(level_bus), 32'(lv(3, 3)));
    goto_edge(61);  chk("lvl_11", 32'(level_bus), 32'(lv(1, 1)));
                    chk("low_11", 32'(low_mask), 32'd3);
                    chk("state_lag", 32'(st_now()), 32'(ST_NEU));
    goto_edge(62);  chk("low_state", 32'(st_now()), 32'(ST_LOW));

    // Feed ch1, saturation, bit0 ignored
    botonFeed = 2'b10;
    goto_edge(63);  chk("feed1", 32'(level_bus), 32'(lv(3, 1)));
                    chk("feed1_low", 32'(low_mask), 32'd1);
    botonFeed = 2'b00;
    goto_edge(64);
    botonFeed = 2'b11;
    goto_edge(65);  chk("feed_sat", 32'(level_bus), 32'(lv(4, 1)));

    // Sleep with feed held high: energy recovers, ch1 keeps decaying
    botonSleep = 1'b1;
    goto_edge(66);  chk("sleep_enter", 32'(st_now()), 32'(ST_SLP));
    botonSleep = 1'b0;
    goto_edge(75);  chk("sleep_lvl_a", 32'(level_bus), 32'(lv(4, 1)));
    goto_edge(76);  chk("recover1", 32'(level_bus), 32'(lv(4, 2)));
    goto_edge(81);  chk("sleep_ch1_decay", 32'(level_bus), 32'(lv(3, 2)));
    goto_edge(96);  chk("recover_full", 32'(level_bus), 32'(lv(3, 4)));
                    chk("still_sleep", 32'(st_now()), 32'(ST_SLP));
    goto_edge(97);  chk("auto_wake", 32'(st_now()), 32'(ST_NEU));
                    chk("wake_low", 32'(low_mask), 32'd0);
    goto_edge(114); chk("feed_hold_once", 32'(level_bus), 32'(lv(2, 4)));

    // Simultaneous sleep+awake ignored, awake edge, reset out of SLEEP
    botonFeed  = 2'b00;
    botonSleep = 1'b1;
    botonAwake = 1'b1;
    goto_edge(115); chk("sleep_awake_same", 32'(st_now()), 32'(ST_NEU));
    botonSleep = 1'b0;
    botonAwake = 1'b0;
    goto_edge(116);
    botonSleep = 1'b1;
    goto_edge(117); chk("sleep_again", 32'(st_now()), 32'(ST_SLP));
    botonSleep = 1'b0;
    botonAwake = 1'b1;
    goto_edge(118); chk("awake_edge", 32'(st_now()), 32'(ST_NEU));
    botonAwake = 1'b0;
    goto_edge(119);
    botonSleep = 1'b1;
    goto_edge(120); chk("sleep_pre_rst", 32'(st_now()), 32'(ST_SLP));
    do_reset();

    // Starvation path
    goto_edge(81);  chk("lvl_zero", 32'(level_bus), 32'(lv(0, 0)));
                    chk("low_zero", 32'(low_mask), 32'd3);
    goto_edge(95);  chk("pre_death", 32'(st_now()), 32'(ST_LOW));
    goto_edge(96);
`ifdef TAMA_DEATH_EN
    chk("death", 32'(st_now()), 32'(ST_DTH));
    botonFeed  = 2'b10;
    botonSleep = 1'b1;
    botonAwake = 1'b1;
    goto_edge(97);  chk("death_feed_ign", 32'(level_bus), 32'(lv(0, 0)));
                    chk("death_sticky", 32'(st_now()), 32'(ST_DTH));
    goto_edge(101); chk("death_frozen", 32'(level_bus), 32'(lv(0, 0)));
                    chk("death_sticky2", 32'(st_now()), 32'(ST_DTH));
`else
    chk("no_death", 32'(st_now()), 32'(ST_LOW));
    botonFeed  = 2'b10;
    botonSleep = 1'b1;
    botonAwake = 1'b1;
    goto_edge(97);  chk("nodeath_feed", 32'(level_bus), 32'(lv(2, 0)));
                    chk("nodeath_low", 32'(st_now()), 32'(ST_LOW));
    goto_edge(101); chk("nodeath_decay", 32'(level_bus), 32'(lv(1, 0)));
                    chk("nodeath_low2", 32'(st_now()), 32'(ST_LOW));
`endif
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", ecnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
